// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster generator: the 640x480@60 timing set
// and the helper that derives the total line/frame length from its regions.
package vga_timing_pkg;

    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int H_ACT_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;
    localparam int V_ACT_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam logic HS_POL_DEF = 1'b0;
    localparam logic VS_POL_DEF = 1'b0;
    localparam int CW_DEF       = 10;

    function automatic int axis_total(int sync, int bp, int act, int fp);
        return sync + bp + act + fp;
    endfunction

    localparam int H_TOT_DEF = axis_total(H_SYNC_DEF, H_BP_DEF, H_ACT_DEF, H_FP_DEF);
    localparam int V_TOT_DEF = axis_total(V_SYNC_DEF, V_BP_DEF, V_ACT_DEF, V_FP_DEF);

endpackage

// File: rtl/raster_axis_ctr.sv
// One raster axis: wrapping position counter plus registered sync/active/coordinate
// decodes taken from the next count so they line up with the counter itself.
module raster_axis_ctr
    import vga_timing_pkg::*;
#(
    parameter int   SYNC = 96,
    parameter int   BP   = 48,
    parameter int   ACT  = 640,
    parameter int   FP   = 16,
    parameter logic POL  = 1'b0,
    parameter int   CW   = 10
) (
    input  logic          clk_25mhz,
    input  logic          rst,
    input  logic          adv,
    output logic [CW-1:0] cnt,
    output logic          sync,
    output logic          in_act,
    output logic [CW-1:0] coord,
    output logic          wrap
);

    localparam int TOT = axis_total(SYNC, BP, ACT, FP);
    localparam logic [CW-1:0] LAST     = CW'(TOT - 1);
    localparam logic [CW-1:0] SYNC_END = CW'(SYNC);
    localparam logic [CW-1:0] ACT_BEG  = CW'(SYNC + BP);
    // FP >= 1 keeps this end bound at or below TOT-1, so it always fits in CW bits.
    localparam logic [CW-1:0] ACT_END  = CW'(SYNC + BP + ACT);

    logic [CW-1:0] cnt_nxt;
    logic          act_nxt;

    assign wrap = adv && (cnt == LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (wrap) begin
            cnt_nxt = '0;
        end else if (adv) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    assign act_nxt = (cnt_nxt >= ACT_BEG) && (cnt_nxt < ACT_END);

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            cnt    <= '0;
            sync   <= POL;
            in_act <= 1'b0;
            coord  <= '0;
        end else begin
            cnt    <= cnt_nxt;
            sync   <= (cnt_nxt < SYNC_END) ? POL : ~POL;
            in_act <= act_nxt;
            coord  <= act_nxt ? (cnt_nxt - ACT_BEG) : '0;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal axis runs every pixel clock, vertical axis
// steps on each horizontal wrap; strobes are registered from the wrap conditions.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_SYNC = H_SYNC_DEF,
    parameter int   H_BP   = H_BP_DEF,
    parameter int   H_ACT  = H_ACT_DEF,
    parameter int   H_FP   = H_FP_DEF,
    parameter int   V_SYNC = V_SYNC_DEF,
    parameter int   V_BP   = V_BP_DEF,
    parameter int   V_ACT  = V_ACT_DEF,
    parameter int   V_FP   = V_FP_DEF,
    parameter logic HS_POL = HS_POL_DEF,
    parameter logic VS_POL = VS_POL_DEF,
    parameter int   CW     = CW_DEF
) (
    input  logic          clk_25mhz,
    input  logic          rst,
    output logic          hsync,
    output logic          vsync,
    output logic          hsync_pulse,
    output logic          vsync_pulse,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic [CW-1:0] px,
    output logic [CW-1:0] py
);

    logic          h_in_act, v_in_act;
    logic [CW-1:0] h_coord, v_coord;
    logic          h_wrap, v_wrap;

    raster_axis_ctr #(
        .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP), .POL(HS_POL), .CW(CW)
    ) u_h_axis (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .adv       (1'b1),
        .cnt       (x),
        .sync      (hsync),
        .in_act    (h_in_act),
        .coord     (h_coord),
        .wrap      (h_wrap)
    );

    raster_axis_ctr #(
        .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP), .POL(VS_POL), .CW(CW)
    ) u_v_axis (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .adv       (h_wrap),
        .cnt       (y),
        .sync      (vsync),
        .in_act    (v_in_act),
        .coord     (v_coord),
        .wrap      (v_wrap)
    );

    // v_wrap already implies h_wrap, so the frame strobe always lands with a line strobe.
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            hsync_pulse <= 1'b0;
            vsync_pulse <= 1'b0;
        end else begin
            hsync_pulse <= h_wrap;
            vsync_pulse <= v_wrap;
        end
    end

    assign active = h_in_act & v_in_act;
    assign px     = active ? h_coord : '0;
    assign py     = active ? v_coord : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, inverted-polarity, scaled and tiny rasters
// checked against hand-computed vectors and an independent raster model.
module tb_vga_timing_gen;

    logic clk_25mhz = 1'b0;
    always #20 clk_25mhz = ~clk_25mhz;

    logic rst, rst_t;

    logic       d_hs, d_vs, d_hp, d_vp, d_act;
    logic [9:0] d_x, d_y, d_px, d_py;
    logic       i_hs, i_vs, i_hp, i_vp, i_act;
    logic [9:0] i_x, i_y, i_px, i_py;
    logic       s_hs, s_vs, s_hp, s_vp, s_act;
    logic [5:0] s_x, s_y, s_px, s_py;
    logic       t_hs, t_vs, t_hp, t_vp, t_act;
    logic [3:0] t_x, t_y, t_px, t_py;

    vga_timing_gen u_def (
        .clk_25mhz(clk_25mhz), .rst(rst), .hsync(d_hs), .vsync(d_vs),
        .hsync_pulse(d_hp), .vsync_pulse(d_vp), .x(d_x), .y(d_y),
        .active(d_act), .px(d_px), .py(d_py)
    );

    vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1)) u_inv (
        .clk_25mhz(clk_25mhz), .rst(rst), .hsync(i_hs), .vsync(i_vs),
        .hsync_pulse(i_hp), .vsync_pulse(i_vp), .x(i_x), .y(i_y),
        .active(i_act), .px(i_px), .py(i_py)
    );

    vga_timing_gen #(
        .H_SYNC(8), .H_BP(4), .H_ACT(20), .H_FP(4),
        .V_SYNC(2), .V_BP(3), .V_ACT(10), .V_FP(2), .CW(6)
    ) u_scl (
        .clk_25mhz(clk_25mhz), .rst(rst), .hsync(s_hs), .vsync(s_vs),
        .hsync_pulse(s_hp), .vsync_pulse(s_vp), .x(s_x), .y(s_y),
        .active(s_act), .px(s_px), .py(s_py)
    );

    vga_timing_gen #(
        .H_SYNC(2), .H_BP(1), .H_ACT(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACT(2), .V_FP(1), .CW(4)
    ) u_tiny (
        .clk_25mhz(clk_25mhz), .rst(rst_t), .hsync(t_hs), .vsync(t_vs),
        .hsync_pulse(t_hp), .vsync_pulse(t_vp), .x(t_x), .y(t_y),
        .active(t_act), .px(t_px), .py(t_py)
    );

    typedef struct packed {
        logic [15:0] x, y;
        logic        hs, vs, act;
        logic [15:0] px, py;
        logic        hp, vp;
    } obs_t;

    typedef struct {
        bit   rst;
        int   n;
        obs_t e;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic obs_t mk(int x, int y, bit hs, bit vs, bit act, int px, int py, bit hp, bit vp);
        obs_t o;
        o.x = 16'(x); o.y = 16'(y); o.hs = hs; o.vs = vs; o.act = act;
        o.px = 16'(px); o.py = 16'(py); o.hp = hp; o.vp = vp;
        return o;
    endfunction

    // Reference raster: outputs as a pure function of position and the region sizes.
    function automatic obs_t model(int mx, int my, bit hpol, bit vpol, int hs, int hb, int ha,
                                   int vs, int vb, int va, bit in_rst);
        bit ax, ay, act, hp;
        ax  = (mx >= hs + hb) && (mx < hs + hb + ha);
        ay  = (my >= vs + vb) && (my < vs + vb + va);
        act = ax && ay;
        hp  = !in_rst && (mx == 0);
        return mk(mx, my, (mx < hs) ? hpol : !hpol, (my < vs) ? vpol : !vpol, act,
                  act ? mx - hs - hb : 0, act ? my - vs - vb : 0, hp, hp && (my == 0));
    endfunction

    task automatic step(inout int mx, inout int my, input int ht, input int vt);
        if (mx == ht - 1) begin
            mx = 0;
            my = (my == vt - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
    endtask

    vec_t tv[14];

    initial begin
        int dx, dy, sx, sy, tx, ty;
        int d_err, i_err, s_err, t_err, d_err_at;
        int d_hs_low, d_hs_high, i_hs_low, d_vs_low;
        int hp_first, hp_second, first_act_x, first_act_y, first_act_px, first_act_py;
        int sframe, s_start, s_period, s_act_cnt, s_vs_low, s_last_x, s_last_y;
        int s_last_px, s_last_py, s_vp_no_hp;
        obs_t o;

        tv[0]  = '{1'b1, 3,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tv[1]  = '{1'b0, 1,  mk(1, 0, 0, 0, 0, 0, 0, 0, 0)};
        tv[2]  = '{1'b0, 1,  mk(2, 0, 1, 0, 0, 0, 0, 0, 0)};
        tv[3]  = '{1'b0, 1,  mk(3, 0, 1, 0, 0, 0, 0, 0, 0)};
        tv[4]  = '{1'b0, 5,  mk(0, 1, 0, 1, 0, 0, 0, 1, 0)};
        tv[5]  = '{1'b0, 1,  mk(1, 1, 0, 1, 0, 0, 0, 0, 0)};
        tv[6]  = '{1'b0, 10, mk(3, 2, 1, 1, 1, 0, 0, 0, 0)};
        tv[7]  = '{1'b0, 3,  mk(6, 2, 1, 1, 1, 3, 0, 0, 0)};
        tv[8]  = '{1'b0, 1,  mk(7, 2, 1, 1, 0, 0, 0, 0, 0)};
        tv[9]  = '{1'b0, 7,  mk(6, 3, 1, 1, 1, 3, 1, 0, 0)};
        tv[10] = '{1'b0, 10, mk(0, 0, 0, 0, 0, 0, 0, 1, 1)};
        tv[11] = '{1'b0, 29, mk(5, 3, 1, 1, 1, 2, 1, 0, 0)};
        tv[12] = '{1'b1, 1,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tv[13] = '{1'b0, 1,  mk(1, 0, 0, 0, 0, 0, 0, 0, 0)};

        // Phase A: default, inverted and scaled rasters from a common reset.
        rst = 1'b1;
        rst_t = 1'b1;
        repeat (3) @(negedge clk_25mhz);
        check("rst.x", int'(d_x), 0);
        check("rst.y", int'(d_y), 0);
        check("rst.hsync", int'(d_hs), 0);
        check("rst.vsync", int'(d_vs), 0);
        check("rst.active", int'(d_act), 0);
        check("rst.px_py", int'(d_px) + int'(d_py), 0);
        check("rst.strobes", int'(d_hp) + int'(d_vp), 0);
        check("rst.inv_hsync", int'(i_hs), 1);
        check("rst.inv_vsync", int'(i_vs), 1);

        dx = 0; dy = 0; sx = 0; sy = 0;
        d_err = 0; i_err = 0; s_err = 0; d_err_at = -1;
        d_hs_low = 0; d_hs_high = 0; i_hs_low = 0; d_vs_low = 1;
        hp_first = -1; hp_second = -1; first_act_x = -1; first_act_y = -1;
        first_act_px = -1; first_act_py = -1;
        sframe = 0; s_start = 0; s_period = -1; s_act_cnt = 0; s_vs_low = 0;
        s_last_x = -1; s_last_y = -1; s_last_px = -1; s_last_py = -1; s_vp_no_hp = 0;
        rst = 1'b0;

        for (int k = 0; k < 28500; k++) begin
            @(negedge clk_25mhz);
            step(dx, dy, 800, 525);
            step(sx, sy, 36, 17);

            o = mk(int'(d_x), int'(d_y), d_hs, d_vs, d_act, int'(d_px), int'(d_py), d_hp, d_vp);
            if (o != model(dx, dy, 1'b0, 1'b0, 96, 48, 640, 2, 33, 480, 1'b0)) begin
                if (d_err == 0) d_err_at = k;
                d_err++;
            end
            o = mk(int'(i_x), int'(i_y), i_hs, i_vs, i_act, int'(i_px), int'(i_py), i_hp, i_vp);
            if (o != model(dx, dy, 1'b1, 1'b1, 96, 48, 640, 2, 33, 480, 1'b0)) i_err++;
            o = mk(int'(s_x), int'(s_y), s_hs, s_vs, s_act, int'(s_px), int'(s_py), s_hp, s_vp);
            if (o != model(sx, sy, 1'b0, 1'b0, 8, 4, 20, 2, 3, 10, 1'b0)) s_err++;

            if (dy == 1) begin
                if (d_hs == 1'b0) d_hs_low++; else d_hs_high++;
                if (i_hs == 1'b0) i_hs_low++;
            end
            if (d_vs == 1'b0) d_vs_low++;
            if (d_hp) begin
                if (hp_first < 0) hp_first = k;
                else if (hp_second < 0) hp_second = k;
            end
            if (d_act && first_act_x < 0) begin
                first_act_x = int'(d_x); first_act_y = int'(d_y);
                first_act_px = int'(d_px); first_act_py = int'(d_py);
            end

            if (s_vp) begin
                if (!s_hp) s_vp_no_hp++;
                if (sframe == 0) begin
                    sframe = 1; s_start = k;
                end else if (sframe == 1) begin
                    sframe = 2; s_period = k - s_start;
                end
            end
            if (sframe == 1) begin
                if (s_vs == 1'b0) s_vs_low++;
                if (s_act) begin
                    s_act_cnt++;
                    s_last_x = int'(s_x); s_last_y = int'(s_y);
                    s_last_px = int'(s_px); s_last_py = int'(s_py);
                end
            end
        end

        check("def.model_mismatches", d_err, 0);
        if (d_err != 0) $display("  first default divergence at cycle %0d", d_err_at);
        check("inv.model_mismatches", i_err, 0);
        check("scl.model_mismatches", s_err, 0);
        check("def.hsync_low_per_line", d_hs_low, 96);
        check("def.hsync_high_per_line", d_hs_high, 704);
        check("inv.hsync_low_per_line", i_hs_low, 704);
        check("def.first_hsync_pulse_cycle", hp_first, 799);
        check("def.hsync_pulse_period", hp_second - hp_first, 800);
        check("def.vsync_low_cycles", d_vs_low, 1600);
        check("def.first_active_x", first_act_x, 144);
        check("def.first_active_y", first_act_y, 35);
        check("def.first_active_px", first_act_px, 0);
        check("def.first_active_py", first_act_py, 0);
        check("scl.frame_period", s_period, 612);
        check("scl.active_per_frame", s_act_cnt, 200);
        check("scl.vsync_low_per_frame", s_vs_low, 72);
        check("scl.vsync_without_hsync", s_vp_no_hp, 0);
        check("scl.last_active_x", s_last_x, 31);
        check("scl.last_active_y", s_last_y, 14);
        check("scl.last_active_px", s_last_px, 19);
        check("scl.last_active_py", s_last_py, 9);

        // Phase B: tiny raster vectors, including a reset at (5,3).
        for (int i = 0; i < 14; i++) begin
            rst_t = tv[i].rst;
            repeat (tv[i].n) @(negedge clk_25mhz);
            check($sformatf("tv%0d.x", i), int'(t_x), int'(tv[i].e.x));
            check($sformatf("tv%0d.y", i), int'(t_y), int'(tv[i].e.y));
            check($sformatf("tv%0d.hsync", i), int'(t_hs), int'(tv[i].e.hs));
            check($sformatf("tv%0d.vsync", i), int'(t_vs), int'(tv[i].e.vs));
            check($sformatf("tv%0d.active", i), int'(t_act), int'(tv[i].e.act));
            check($sformatf("tv%0d.px", i), int'(t_px), int'(tv[i].e.px));
            check($sformatf("tv%0d.py", i), int'(t_py), int'(tv[i].e.py));
            check($sformatf("tv%0d.hsync_pulse", i), int'(t_hp), int'(tv[i].e.hp));
            check($sformatf("tv%0d.vsync_pulse", i), int'(t_vp), int'(tv[i].e.vp));
        end

        // Exhaustive tiny raster over three frames, continuing from (1,0).
        tx = 1; ty = 0; t_err = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk_25mhz);
            step(tx, ty, 8, 5);
            o = mk(int'(t_x), int'(t_y), t_hs, t_vs, t_act, int'(t_px), int'(t_py), t_hp, t_vp);
            if (o != model(tx, ty, 1'b0, 1'b0, 2, 1, 4, 1, 1, 2, 1'b0)) t_err++;
        end
        check("tiny.model_mismatches", t_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
